// File: rtl/dot4_pkg.sv
// Shared types and constants for the dot4 multiply-accumulate block.
// Holds the FSM encoding, the operand/product widths and the accumulator-width helper.
package dot4_pkg;

    localparam int OPW   = 4;
    localparam int PRODW = 8;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Wide enough for LEN products of 15*15 without overflow.
    function automatic int acc_width(input int len);
        return PRODW + $clog2(len);
    endfunction

endpackage

// File: rtl/mul4x4.sv
// 4x4 unsigned array multiplier; purely combinational, zero latency.
// No handshake and no backpressure: Z follows A/B within the same cycle.
module mul4x4
    import dot4_pkg::*;
(
    input  logic [OPW-1:0]   A,
    input  logic [OPW-1:0]   B,
    output logic [PRODW-1:0] Z
);

    always_comb begin
        Z = '0;
        for (int i = 0; i < OPW; i++) begin
            if (B[i]) begin
                Z = Z + (PRODW'(A) << i);
            end
        end
    end

endmodule

// File: rtl/dot4_mac.sv
// Streams LEN operand pairs into an external multiplier and accumulates the products;
// latency 2 edges from the last accept to out_valid; in_ready drops while a result is pending.
module dot4_mac
    import dot4_pkg::*;
#(
    parameter int LEN   = 4,
    parameter int ACC_W = acc_width(LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   in_a,
    input  logic [OPW-1:0]   in_b,
    output logic [OPW-1:0]   mul_a,
    output logic [OPW-1:0]   mul_b,
    input  logic [PRODW-1:0] mul_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             busy
);

    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             s1_valid_q, s1_valid_d;
    logic [OPW-1:0]   mul_a_q, mul_a_d;
    logic [OPW-1:0]   mul_b_q, mul_b_d;
    logic             accept;

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign out_sum   = acc_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign busy      = (count_q != '0) || (state_q != ST_ACCUM);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        acc_d      = acc_q;
        s1_valid_d = 1'b0;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;

        // Product on mul_p belongs to the pair registered on the previous edge.
        if (s1_valid_q) begin
            acc_d = acc_q + ACC_W'(mul_p);
        end

        if (accept) begin
            mul_a_d    = in_a;
            mul_b_d    = in_b;
            s1_valid_d = 1'b1;
            if (count_q == CNT_LAST) begin
                count_d = '0;
                state_d = ST_FLUSH;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end

        case (state_q)
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_ACCUM;
                    acc_d   = '0;
                end
            end
            default: ;
        endcase

        // Abort discards everything in flight but leaves the multiplier operands alone.
        if (clr) begin
            state_d    = ST_ACCUM;
            count_d    = '0;
            acc_d      = '0;
            s1_valid_d = 1'b0;
            mul_a_d    = mul_a_q;
            mul_b_d    = mul_b_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ACCUM;
            count_q    <= '0;
            acc_q      <= '0;
            s1_valid_q <= 1'b0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            s1_valid_q <= s1_valid_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
        end
    end

endmodule
